mem_port_arbiter: RTL and testbench

- Shares one unified single-ported memory between the instruction-fetch and data-access sides of the multi-cycle CPU datapath.
- Grants one requester at a time and holds that requester's command on the memory port for a fixed access latency.
- Returns read data with a one-cycle ready pulse.
- Data accesses have priority; a streak limit guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data sides.
// Ports: clk/reset (async, active-high); i_req/i_addr -> i_rdata/i_ready (fetch);
// d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready (data); m_readM/m_writeM/m_address/
// m_wdata/m_rdata drive the memory; busy is high while an access holds the port.
module mem_port_arbiter #(
    parameter int WORD_SIZE       = 16,
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4,
    parameter int CNT_W           = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic                 busy
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_DATA_STREAK);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    state_t               r_state, w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [SW-1:0]        r_streak;
    logic [WORD_SIZE-1:0] r_addr, r_wdata;
    logic                 r_we;
    logic                 w_i_req, w_d_req, w_grant_d, w_done;

    // A port's request is ignored in its own ready cycle so a held req cannot re-grant.
    assign w_i_req   = i_req & ~i_ready;
    assign w_d_req   = d_req & ~d_ready;
    assign w_grant_d = w_d_req & (~w_i_req | (r_streak < MAX_S));
    assign w_done    = (r_state != IDLE) && (r_cnt == '0);

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = w_grant_d ? D_ACC : (w_i_req ? I_ACC : IDLE);
        else if (w_done)
            w_next = IDLE;
    end

    assign busy      = r_state != IDLE;
    assign m_readM   = (r_state == I_ACC) | ((r_state == D_ACC) & ~r_we);
    assign m_writeM  = (r_state == D_ACC) & r_we;
    assign m_address = busy ? r_addr : '0;
    assign m_wdata   = m_writeM ? r_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_streak <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
        end else begin
            i_ready <= w_done && (r_state == I_ACC);
            d_ready <= w_done && (r_state == D_ACC);
            if (w_done && r_state == I_ACC) i_rdata <= m_rdata;
            if (w_done && r_state == D_ACC && !r_we) d_rdata <= m_rdata;
            if (r_state != IDLE) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (w_grant_d) begin
                r_addr   <= d_addr;
                r_we     <= d_we;
                r_wdata  <= d_wdata;
                r_cnt    <= LAT_M1;
                // Only data grants that make a waiting fetch wait longer extend the streak.
                r_streak <= w_i_req ? ((r_streak == MAX_S) ? r_streak : r_streak + 1'b1) : '0;
            end else if (w_i_req) begin
                r_addr   <= i_addr;
                r_we     <= 1'b0;
                r_wdata  <= '0;
                r_cnt    <= LAT_M1;
                r_streak <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and a randomized model check.
module tb_mem_port_arbiter;
    localparam int L    = 2;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata, m_address, m_wdata, m_rdata;
    logic        i_ready, d_ready, m_readM, m_writeM, busy;

    logic [15:0] mem [256];
    logic [15:0] mdl_mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    assign m_rdata = mem[m_address[7:0]];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WORD_SIZE(16), .MEM_LATENCY(L), .MAX_DATA_STREAK(MAXS), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
    );

    typedef struct {
        logic ir; logic [15:0] ia; logic dr; logic dwe; logic [15:0] da; logic [15:0] dw;
        logic e_rd; logic e_wr; logic [15:0] e_ad; logic [15:0] e_wd;
        logic e_ir; logic [15:0] e_ird; logic e_dr; logic [15:0] e_drd; logic e_busy;
    } vec_t;

    vec_t tab [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_port [11];
        int port_seq [$];
        logic [15:0] addr_seq [$];
        int dn, dj;
        logic prev_busy;
        int gnt_n, owner, streak;
        logic mwe, cmd, rdy, ei, ed, ewr, erd, iq, dq, i_seen, d_seen;
        logic [15:0] maddr, mwdata, exp_rd, exp_ird, exp_drd, ea;

        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 7);
        mem[8'h10] = 16'hA5A5;
        mem[8'h40] = 16'hBEEF;

        tab[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        tab[1] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1};
        tab[2] = tab[1];
        tab[3] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'hA5A5, 1'b0, 16'h0, 1'b0};
        tab[4] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'hA5A5, 1'b0, 16'h0, 1'b0};
        tab[5] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'hA5A5, 1'b0, 16'h0, 1'b1};
        tab[6] = tab[5];
        tab[7] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'hA5A5, 1'b1, 16'h0, 1'b0};
        tab[8] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'hA5A5, 1'b0, 16'h0, 1'b0};

        // Reset values, checked while reset is held.
        reset = 1'b1;
        idle_in();
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_readM", 32'(m_readM), 0);
        chk("rst_writeM", 32'(m_writeM), 0);
        chk("rst_address", 32'(m_address), 0);
        chk("rst_wdata", 32'(m_wdata), 0);
        chk("rst_i_ready", 32'(i_ready), 0);
        chk("rst_d_ready", 32'(d_ready), 0);
        chk("rst_i_rdata", 32'(i_rdata), 0);
        chk("rst_d_rdata", 32'(d_rdata), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single fetch then a data write, row per cycle.
        for (int r = 0; r < 9; r++) begin
            i_req = tab[r].ir; i_addr = tab[r].ia;
            d_req = tab[r].dr; d_we = tab[r].dwe; d_addr = tab[r].da; d_wdata = tab[r].dw;
            @(negedge clk);
            chk($sformatf("tab%0d_readM", r), 32'(m_readM), 32'(tab[r].e_rd));
            chk($sformatf("tab%0d_writeM", r), 32'(m_writeM), 32'(tab[r].e_wr));
            chk($sformatf("tab%0d_address", r), 32'(m_address), 32'(tab[r].e_ad));
            chk($sformatf("tab%0d_wdata", r), 32'(m_wdata), 32'(tab[r].e_wd));
            chk($sformatf("tab%0d_i_ready", r), 32'(i_ready), 32'(tab[r].e_ir));
            chk($sformatf("tab%0d_i_rdata", r), 32'(i_rdata), 32'(tab[r].e_ird));
            chk($sformatf("tab%0d_d_ready", r), 32'(d_ready), 32'(tab[r].e_dr));
            chk($sformatf("tab%0d_d_rdata", r), 32'(d_rdata), 32'(tab[r].e_drd));
            chk($sformatf("tab%0d_busy", r), 32'(busy), 32'(tab[r].e_busy));
            next_cycle();
        end

        // Simultaneous requests: data first, fetch granted in the d_ready cycle.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            i_req = (k <= 6); i_addr = 16'h0010;
            d_req = (k <= 3); d_we = 1'b0; d_addr = 16'h0040;
            @(negedge clk);
            chk($sformatf("sim%0d_d_ready", k), 32'(d_ready), 32'(k == 3));
            chk($sformatf("sim%0d_i_ready", k), 32'(i_ready), 32'(k == 6));
            chk($sformatf("sim%0d_readM", k), 32'(m_readM), 32'(k inside {1, 2, 4, 5}));
            chk($sformatf("sim%0d_address", k), 32'(m_address),
                (k inside {1, 2}) ? 32'h40 : ((k inside {4, 5}) ? 32'h10 : 32'h0));
            if (k == 3) chk("sim_d_rdata", 32'(d_rdata), 32'hBEEF);
            if (k == 6) chk("sim_i_rdata", 32'(i_rdata), 32'hA5A5);
            next_cycle();
        end

        // Starvation guard: the fetch side re-requests right after each data completion.
        do_reset();
        exp_port = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 1};
        dn = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 300 && port_seq.size() < 11; c++) begin
            if (d_ready) dn++;
            d_req = 1'b1; d_we = 1'b1; d_addr = 16'(16'h0100 + dn); d_wdata = 16'(16'hD000 + dn);
            i_req = ~d_ready; i_addr = 16'h0020;
            @(negedge clk);
            if (busy && !prev_busy) begin
                port_seq.push_back(m_writeM ? 2 : 1);
                addr_seq.push_back(m_address);
            end
            prev_busy = busy;
            next_cycle();
        end
        chk("starve_grants", 32'(port_seq.size()), 11);
        dj = 0;
        for (int g = 0; g < 11 && g < port_seq.size(); g++) begin
            ea = (exp_port[g] == 2) ? 16'(16'h0100 + dj) : 16'h0020;
            if (exp_port[g] == 2) dj++;
            chk($sformatf("starve%0d_port", g), 32'(port_seq[g]), 32'(exp_port[g]));
            chk($sformatf("starve%0d_addr", g), 32'(addr_seq[g]), 32'(ea));
        end

        // Asynchronous reset in the second latency cycle of a data write.
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5555;
        next_cycle();
        next_cycle();
        chk("arst_pre_writeM", 32'(m_writeM), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_writeM", 32'(m_writeM), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_address", 32'(m_address), 0);
        chk("arst_wdata", 32'(m_wdata), 0);
        idle_in();
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("arst%0d_no_d_ready", k), 32'(d_ready), 0);
            next_cycle();
        end
        for (int k = 0; k < 5; k++) begin
            i_req = (k <= 3); i_addr = 16'h0010;
            @(negedge clk);
            chk($sformatf("arst_fetch%0d_i_ready", k), 32'(i_ready), 32'(k == 3));
            if (k == 3) chk("arst_fetch_i_rdata", 32'(i_rdata), 32'hA5A5);
            next_cycle();
        end

        // Randomized traffic against a cycle-numbered reference model.
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            mdl_mem[i] = mem[i];
        end
        do_reset();
        gnt_n = -1000; owner = 0; streak = 0;
        mwe = 1'b0; maddr = '0; mwdata = '0; exp_rd = '0; exp_ird = '0; exp_drd = '0;
        i_seen = 1'b0; d_seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!i_req || i_seen) begin
                i_seen = 1'b0;
                i_req = 1'($urandom_range(0, 1));
                i_addr = 16'($urandom);
            end
            if (!d_req || d_seen) begin
                d_seen = 1'b0;
                d_req = 1'($urandom_range(0, 1));
                d_we = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            @(negedge clk);
            cmd = (owner != 0) && (n > gnt_n) && (n <= gnt_n + L);
            rdy = (owner != 0) && (n == gnt_n + L + 1);
            ei = rdy && owner == 1;
            ed = rdy && owner == 2;
            if (ei) exp_ird = exp_rd;
            if (ed && !mwe) exp_drd = exp_rd;
            ewr = cmd && owner == 2 && mwe;
            erd = cmd && !ewr;
            chk("rnd_busy", 32'(busy), 32'(cmd));
            chk("rnd_readM", 32'(m_readM), 32'(erd));
            chk("rnd_writeM", 32'(m_writeM), 32'(ewr));
            chk("rnd_address", 32'(m_address), cmd ? 32'(maddr) : 32'h0);
            if (ewr || !cmd) chk("rnd_wdata", 32'(m_wdata), ewr ? 32'(mwdata) : 32'h0);
            chk("rnd_i_ready", 32'(i_ready), 32'(ei));
            chk("rnd_d_ready", 32'(d_ready), 32'(ed));
            chk("rnd_both_ready", 32'(i_ready & d_ready), 0);
            chk("rnd_i_rdata", 32'(i_rdata), 32'(exp_ird));
            chk("rnd_d_rdata", 32'(d_rdata), 32'(exp_drd));
            if (m_writeM) mem[m_address[7:0]] = m_wdata;
            if (i_ready) i_seen = 1'b1;
            if (d_ready) d_seen = 1'b1;
            if (!cmd) begin
                iq = i_req && !ei;
                dq = d_req && !ed;
                if (dq && (!iq || streak < MAXS)) begin
                    owner = 2;
                    streak = iq ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                    maddr = d_addr; mwe = d_we; mwdata = d_wdata;
                    exp_rd = mdl_mem[d_addr[7:0]];
                    if (d_we) mdl_mem[d_addr[7:0]] = d_wdata;
                    gnt_n = n;
                end else if (iq) begin
                    owner = 1;
                    streak = 0;
                    maddr = i_addr; mwe = 1'b0; mwdata = '0;
                    exp_rd = mdl_mem[i_addr[7:0]];
                    gnt_n = n;
                end
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
